// File: rtl/serial_frame_ctrl_if.sv
// Bundles the word-level request/result signals and the bit-serial link of serial_frame_ctrl.
// Latency: none; this is wiring only.
// Backpressure: none; Start is simply ignored by the controller while a frame is in flight.
// Ports: Start/Din request a frame; SX/SEn/SClr drive the serial stage and SN returns from it;
//        Busy/Done/Dout/Ovf report status and the reassembled result.
interface serial_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             Start;
    logic [WIDTH-1:0] Din;
    logic             SN;
    logic             SX;
    logic             SEn;
    logic             SClr;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Dout;
    logic             Ovf;

    // master: the requester, which also hosts the downstream serial stage
    modport master (
        output Start, Din, SN,
        input  SX, SEn, SClr, Busy, Done, Dout, Ovf
    );

    // slave: the frame controller itself
    modport slave (
        input  Start, Din, SN,
        output SX, SEn, SClr, Busy, Done, Dout, Ovf
    );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Serialises a WIDTH-bit word LSB-first to a bit-serial stage and reassembles its returned bits.
// Latency: accepted Start edge to Done high is WIDTH+1 cycles; the frame period is WIDTH+3 cycles.
// Backpressure: Start is honoured only in IDLE; requests made in other states are dropped.
// Ports: CLK and Reset (asynchronous, active-low) plus the slave side of serial_frame_ctrl_if.
module serial_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    serial_frame_ctrl_if.slave bus
);
    // Bit-counter width is derived from WIDTH and is not meant to be overridden.
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLR   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] dout;
    logic [CNTW-1:0]  cnt;
    logic             din_msb;
    logic             ovf;

    // Returned bits enter at the top and walk down, so the first one ends in bit 0.
    assign res_nxt = {bus.SN, res[WIDTH-1:1]};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            res     <= '0;
            dout    <= '0;
            cnt     <= '0;
            din_msb <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        shreg   <= bus.Din;
                        din_msb <= bus.Din[WIDTH-1];
                        cnt     <= '0;
                        state   <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    shreg <= shreg >> 1;
                    res   <= res_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // Publish on the last data edge so the final SN is included;
                        // res_nxt[WIDTH-1] is that SN, i.e. the new Dout MSB.
                        dout  <= res_nxt;
                        ovf   <= din_msb & bus.SN;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Link outputs decode from state only, so Start never reaches an output combinationally.
    assign bus.SClr = (state == ST_CLR);
    assign bus.SEn  = (state == ST_SHIFT);
    assign bus.SX   = (state == ST_SHIFT) & shreg[0];
    assign bus.Busy = (state == ST_CLR) | (state == ST_SHIFT);
    assign bus.Done = (state == ST_DONE);
    assign bus.Dout = dout;
    assign bus.Ovf  = ovf;
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl at WIDTH=4 and WIDTH=6, each driving a serial two's-complement negator.
// Latency: frames are predicted by cycle arithmetic; the expected results are queued at acceptance.
// Backpressure: Start is driven freely; the model decides which requests the controller must take.
module tb_serial_frame_ctrl;
    localparam int NI = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_frame_ctrl_if #(.WIDTH(4)) if4 ();
    serial_frame_ctrl_if #(.WIDTH(6)) if6 ();

    serial_frame_ctrl #(.WIDTH(4)) dut4 (.CLK(clk), .Reset(rst_n), .bus(if4));
    serial_frame_ctrl #(.WIDTH(6)) dut6 (.CLK(clk), .Reset(rst_n), .bus(if6));

    function automatic int wd(int i);
        return (i == 0) ? 4 : 6;
    endfunction

    function automatic logic [31:0] msk(int i);
        return (32'd1 << wd(i)) - 32'd1;
    endfunction

    // Stimulus-side signals, one slot per instance.
    logic        start_v [NI];
    logic [31:0] din_v   [NI];
    logic        seen    [NI] = '{1'b0, 1'b0};

    logic        o_sx [NI], o_sen [NI], o_sclr [NI], o_busy [NI], o_done [NI], o_ovf [NI];
    logic [31:0] o_dout [NI];

    assign if4.Start = start_v[0];
    assign if4.Din   = din_v[0][3:0];
    assign if6.Start = start_v[1];
    assign if6.Din   = din_v[1][5:0];

    // Serial negator: copy bits up to and including the first 1, invert the rest.
    assign if4.SN = seen[0] ? ~if4.SX : if4.SX;
    assign if6.SN = seen[1] ? ~if6.SX : if6.SX;

    assign o_sx[0]   = if4.SX;   assign o_sx[1]   = if6.SX;
    assign o_sen[0]  = if4.SEn;  assign o_sen[1]  = if6.SEn;
    assign o_sclr[0] = if4.SClr; assign o_sclr[1] = if6.SClr;
    assign o_busy[0] = if4.Busy; assign o_busy[1] = if6.Busy;
    assign o_done[0] = if4.Done; assign o_done[1] = if6.Done;
    assign o_ovf[0]  = if4.Ovf;  assign o_ovf[1]  = if6.Ovf;
    assign o_dout[0] = 32'(if4.Dout);
    assign o_dout[1] = 32'(if6.Dout);

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (o_sclr[i])
                seen[i] <= 1'b0;
            else if (o_sen[i] && o_sx[i])
                seen[i] <= 1'b1;
        end
    end

    // Reference model: a request is taken when the controller is free again, which is
    // WIDTH+3 edges after the previous acceptance. Expected result is -Din modulo 2^WIDTH.
    typedef struct {
        logic [31:0] d;
        logic        o;
    } exp_t;

    int          cyc = 0;
    int          acc   [NI] = '{0, 0};
    bit          act   [NI] = '{1'b0, 1'b0};
    int          nfree [NI] = '{0, 0};
    logic [31:0] fdin  [NI] = '{32'd0, 32'd0};
    exp_t        sb    [NI][$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                act[i]   = 1'b0;
                nfree[i] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                if (act[i] && (cyc - acc[i] > wd(i) + 1))
                    act[i] = 1'b0;
                if (start_v[i] && cyc >= nfree[i]) begin
                    acc[i]   = cyc;
                    act[i]   = 1'b1;
                    nfree[i] = cyc + wd(i) + 3;
                    fdin[i]  = din_v[i] & msk(i);
                    e.d      = (32'd0 - fdin[i]) & msk(i);
                    e.o      = fdin[i][wd(i)-1] & e.d[wd(i)-1];
                    sb[i].push_back(e);
                end
            end
        end
    end

    // Monitor / scoreboard.
    int          total = 0;
    int          bad   = 0;
    bit          fin   = 1'b0;
    logic [31:0] hold_d [NI] = '{32'd0, 32'd0};
    logic        hold_o [NI] = '{1'b0, 1'b0};

    task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s w%0d t=%0t: got %0h expected %0h", nm, wd(i), $time, got, want);
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            int   rel;
            logic a, e_sclr, e_sen, e_busy, e_done, e_sx;
            rel    = cyc - acc[i];
            a      = act[i] && rst_n;
            e_sclr = a && (rel == 0);
            e_sen  = a && (rel >= 1) && (rel <= wd(i));
            e_busy = a && (rel <= wd(i));
            e_done = a && (rel == wd(i) + 1);
            e_sx   = 1'b0;
            if (e_sen)
                e_sx = fdin[i][rel-1];

            if (!rst_n) begin
                sb[i].delete();
                hold_d[i] = 32'd0;
                hold_o[i] = 1'b0;
            end else if (o_done[i]) begin
                if (sb[i].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done w%0d t=%0t: got Done=1 expected no pending frame", wd(i), $time);
                end else begin
                    exp_t e;
                    e = sb[i].pop_front();
                    hold_d[i] = e.d;
                    hold_o[i] = e.o;
                end
            end

            chk("sclr", i, 32'(o_sclr[i]), 32'(e_sclr));
            chk("sen",  i, 32'(o_sen[i]),  32'(e_sen));
            chk("busy", i, 32'(o_busy[i]), 32'(e_busy));
            chk("done", i, 32'(o_done[i]), 32'(e_done));
            chk("sx",   i, 32'(o_sx[i]),   32'(e_sx));
            chk("dout", i, o_dout[i],      hold_d[i]);
            chk("ovf",  i, 32'(o_ovf[i]),  32'(hold_o[i]));
            if (fin)
                chk("sb_drain", i, 32'(sb[i].size()), 32'd0);
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle Start on instance i (the other stays idle).
    task automatic pulse(int i, logic [31:0] d);
        @(negedge clk);
        start_v[i] = 1'b1;
        din_v[i]   = d;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0;
            din_v[i]   = 32'd0;
        end
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // 1100 on WIDTH=4 and 011010 on WIDTH=6 together.
        @(negedge clk);
        start_v[0] = 1'b1; din_v[0] = 32'hC;
        start_v[1] = 1'b1; din_v[1] = 32'h1A;
        @(negedge clk);
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        idle(10);

        // Most-negative value, then zero.
        pulse(0, 32'h8);
        idle(8);
        pulse(0, 32'h0);
        idle(8);

        // Start held high: frames every WIDTH+3 cycles.
        @(negedge clk);
        start_v[0] = 1'b1; din_v[0] = 32'h3;
        idle(30);
        start_v[0] = 1'b0;
        idle(8);

        // Din changes right after acceptance.
        pulse(0, 32'h2);
        din_v[0] = 32'hF;
        idle(8);

        // Reset during the third SHIFT cycle.
        @(negedge clk);
        start_v[0] = 1'b1; din_v[0] = 32'h5;
        start_v[1] = 1'b1; din_v[1] = 32'h2A;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        pulse(0, 32'h5);
        idle(8);

        // Random requests and data on both instances.
        repeat (400) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                start_v[i] = ($urandom_range(0, 3) == 0);
                din_v[i]   = $urandom;
            end
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            start_v[i] = 1'b0;
        idle(12);

        fin = 1'b1;
        idle(2);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
